// File: rtl/cnt_seq_ctrl.sv
// Run/pause/load sequencer for a WIDTH-bit counter, stepped by a single-clock prescaler tick.
// Optional CNT_CTRL_DIR_EN adds a dir input for down counting.
module cnt_seq_ctrl #(
  parameter int DIV   = 500,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             oneshot,
`ifdef CNT_CTRL_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             wrap,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           st_q, st_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_d, lim_q, lim_d;
  logic             os_q, os_d;
  logic             tick_d, wrap_d, done_d;
  logic             down;

`ifdef CNT_CTRL_DIR_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  always_comb begin
    st_d   = st_q;
    pre_d  = pre_q;
    cnt_d  = cnt;
    lim_d  = lim_q;
    os_d   = os_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    done_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
      pre_d = '0;
      st_d  = IDLE;
    end else if (load) begin
      cnt_d = load_val;
      pre_d = '0;
      st_d  = IDLE;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (start) begin
            st_d  = RUN;
            lim_d = limit;
            os_d  = oneshot;
            pre_d = '0;
          end
        end
        RUN: begin
          if (pre_q == PRE_MAX) begin
            pre_d  = '0;
            tick_d = 1'b1;
            // Terminal value is lim_q going up and zero going down.
            if (down ? (cnt == '0) : (cnt == lim_q)) begin
              if (os_q) begin
                done_d = 1'b1;
                st_d   = DONE;
              end else begin
                cnt_d  = down ? lim_q : '0;
                wrap_d = 1'b1;
              end
            end else begin
              cnt_d = down ? (cnt - WIDTH'(1)) : (cnt + WIDTH'(1));
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
          if (stop && st_d == RUN) st_d = HOLD;
        end
        HOLD: begin
          if (start) st_d = RUN;
        end
        DONE: begin
          if (start) begin
            st_d  = RUN;
            lim_d = limit;
            os_d  = oneshot;
            pre_d = '0;
            cnt_d = down ? limit : '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      pre_q <= '0;
      cnt   <= '0;
      lim_q <= '0;
      os_q  <= 1'b0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      st_q  <= st_d;
      pre_q <= pre_d;
      cnt   <= cnt_d;
      lim_q <= lim_d;
      os_q  <= os_d;
      tick  <= tick_d;
      wrap  <= wrap_d;
      done  <= done_d;
    end
  end

  assign busy  = (st_q == RUN) || (st_q == HOLD);
  assign state = st_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl (DIV=4, WIDTH=4): directed scenarios plus random commands vs a cycle model.
module tb_cnt_seq_ctrl;
  localparam int DIV   = 4;
  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, clear, load, oneshot;
  logic [WIDTH-1:0] load_val, limit;
  logic [WIDTH-1:0] cnt;
  logic             tick, wrap, done, busy;
  logic [1:0]       state;
`ifdef CNT_CTRL_DIR_EN
  logic             dir = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state (plain integers)
  int m_st, m_cnt, m_pre, m_lim, m_os, m_tick, m_wrap, m_done;

  cnt_seq_ctrl #(.DIV(DIV), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val), .limit(limit), .oneshot(oneshot),
`ifdef CNT_CTRL_DIR_EN
    .dir(dir),
`endif
    .cnt(cnt), .tick(tick), .wrap(wrap), .done(done), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_st = 0; m_cnt = 0; m_pre = 0; m_lim = 0; m_os = 0;
    m_tick = 0; m_wrap = 0; m_done = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs as currently driven.
  task automatic model_clk();
    m_tick = 0; m_wrap = 0; m_done = 0;
    if (clear) begin
      m_cnt = 0; m_pre = 0; m_st = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_pre = 0; m_st = 0;
    end else begin
      case (m_st)
        0: if (start) begin
             m_st = 1; m_lim = int'(limit); m_os = int'(oneshot); m_pre = 0;
           end
        1: begin
             m_pre = m_pre + 1;
             if (m_pre == DIV) begin
               m_pre = 0;
               m_tick = 1;
               if (m_cnt == m_lim) begin
                 if (m_os != 0) begin m_done = 1; m_st = 3; end
                 else begin m_cnt = 0; m_wrap = 1; end
               end else begin
                 m_cnt = (m_cnt + 1) % MOD;
               end
             end
             if (stop && m_st == 1) m_st = 2;
           end
        2: if (start) m_st = 1;
        default: if (start) begin
             m_st = 1; m_cnt = 0; m_pre = 0; m_lim = int'(limit); m_os = int'(oneshot);
           end
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clk();
    #1;
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("done", 32'(done), 32'(m_done));
    chk("state", 32'(state), 32'(m_st));
    chk("busy", 32'(busy), 32'((m_st == 1 || m_st == 2) ? 1 : 0));
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 0; stop = 0; clear = 0; load = 0; oneshot = 0;
    load_val = '0; limit = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_pulses", 32'({tick, wrap, done, busy}), 0);
    @(negedge clk);
    rst = 1'b1;

    // wrap mode: limit=3 gives 1,2,3,0 with wrap on the return to 0
    limit = 4'd3; oneshot = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      repeat (DIV) cyc();
      chk("wrap_seq_cnt", 32'(cnt), 32'(k % 4));
      chk("wrap_seq_tick", 32'(tick), 1);
      chk("wrap_seq_wrap", 32'(wrap), 32'((k == 4) ? 1 : 0));
    end

    // one-shot: limit=2 stops at 2 with a single done pulse
    clear = 1'b1; cyc(); clear = 1'b0;
    limit = 4'd2; oneshot = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    repeat (DIV) cyc();
    chk("os_cnt1", 32'(cnt), 1);
    repeat (DIV) cyc();
    chk("os_cnt2", 32'(cnt), 2);
    repeat (DIV) cyc();
    chk("os_done", 32'(done), 1);
    chk("os_state", 32'(state), 3);
    chk("os_cnt_hold", 32'(cnt), 2);
    cyc();
    chk("os_done_pulse", 32'(done), 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("os_restart_cnt", 32'(cnt), 0);
    chk("os_restart_state", 32'(state), 1);

    // hold keeps prescaler phase: stop two cycles after a tick
    repeat (DIV) cyc();
    chk("hold_pre_tick", 32'(tick), 1);
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("hold_state", 32'(state), 2);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("hold_cnt", 32'(cnt), 1);
    end
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk("resume_no_tick", 32'(tick), 0);
    cyc();
    chk("resume_tick", 32'(tick), 1);
    chk("resume_cnt", 32'(cnt), 2);

    // command priority and load
    clear = 1'b1; load = 1'b1; start = 1'b1; load_val = 4'd7;
    cyc();
    clear = 1'b0; load = 1'b0; start = 1'b0;
    chk("prio_cnt", 32'(cnt), 0);
    chk("prio_state", 32'(state), 0);
    load_val = 4'd9; load = 1'b1; cyc(); load = 1'b0;
    chk("load_cnt", 32'(cnt), 9);
    chk("load_state", 32'(state), 0);

    // asynchronous reset while a tick is showing with cnt=5
    limit = 4'd9; oneshot = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    while (!(m_tick == 1 && m_cnt == 5) && n < 200) begin
      cyc();
      n++;
    end
    chk("reach_cnt5", 32'((n < 200) ? 1 : 0), 1);
    chk("pre_rst_tick", 32'(tick), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_pulses", 32'({tick, wrap, done, busy}), 0);
    @(negedge clk);
    rst = 1'b1;
    mreset();

    // randomized command traffic against the model
    for (int k = 0; k < 3000; k++) begin
      clear    = ($urandom_range(99) < 2);
      load     = ($urandom_range(99) < 3);
      stop     = ($urandom_range(99) < 5);
      start    = ($urandom_range(99) < 10);
      oneshot  = $urandom_range(1);
      limit    = WIDTH'($urandom_range(MOD - 1));
      load_val = WIDTH'($urandom_range(MOD - 1));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
